// File: rtl/game_link_pkg.sv
// game_link_pkg: shared constants and frame FSM type for the board-to-board game link
package game_link_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int FRAME_LEN = 8;
  localparam logic [10:0] BALL_X_RST = 11'd510;
  localparam logic [10:0] BALL_Y_RST = 11'd377;
  typedef enum logic [1:0] {HUNT, COLLECT, CHECK} frame_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART byte receiver with 2-FF input synchronizer and start-glitch rejection
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 564
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       stop_err
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  rx_state_t state;
  logic [2:0] sync;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic rx_s, fall;
  assign rx_s = sync[1];
  assign fall = sync[2] & ~sync[1];
  // synchronize rx, find start edge, then sample mid-bit for data and stop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= 3'b111;
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      data <= '0;
      byte_valid <= 1'b0;
      stop_err <= 1'b0;
    end else begin
      sync <= {sync[1:0], rx};
      byte_valid <= 1'b0;
      case (state)
        IDLE: if (fall) begin
          state <= START;
          cnt <= '0;
        end
        START: if (cnt == HALF) begin
          cnt <= '0;
          bit_idx <= '0;
          state <= rx_s ? IDLE : DATA;
        end else cnt <= cnt + 1'b1;
        DATA: if (cnt == FULL) begin
          cnt <= '0;
          data <= {rx_s, data[7:1]};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) state <= STOP;
        end else cnt <= cnt + 1'b1;
        STOP: if (cnt == FULL) begin
          cnt <= '0;
          byte_valid <= 1'b1;
          stop_err <= ~rx_s;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: rtl/game_state_rx.sv
// game_state_rx: receives 8-byte game-state frames and exposes the last validated state
module game_state_rx
  import game_link_pkg::*;
#(
  parameter int CLK_FREQ = 65_000_000,
  parameter int BAUD = 115_200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int BYTE_TIMEOUT_BITS = 20
) (
  input  logic        clk65MHz,
  input  logic        rst_n,
  input  logic        rx,
  output logic [10:0] x_pos_of_ball,
  output logic [10:0] y_pos_of_ball,
  output logic [3:0]  points_player_1,
  output logic [3:0]  points_player_2,
  output logic [1:0]  who_won,
  output logic        frame_valid,
  output logic        frame_err
);
  localparam int TO = BYTE_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO + 1);
  logic [7:0] data;
  logic byte_valid, stop_err, good, ferr;
  frame_state_t state;
  logic [2:0] idx;
  logic [7:0] xr;
  logic [7:0] sh [FRAME_LEN];
  logic [TW-1:0] tcnt;
  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk65MHz),
    .rst_n(rst_n),
    .rx(rx),
    .data(data),
    .byte_valid(byte_valid),
    .stop_err(stop_err)
  );
  assign good = ~ferr && sh[7] == xr && sh[1][7:3] == 5'd0 && sh[3][7:3] == 5'd0
             && sh[6][7:2] == 6'd0 && sh[6][1:0] != 2'd3;
  // frame FSM: hunt for sync, collect payload into shadow regs, commit only good frames
  always_ff @(posedge clk65MHz or negedge rst_n)
    if (!rst_n) begin
      state <= HUNT;
      idx <= '0;
      xr <= '0;
      ferr <= 1'b0;
      tcnt <= '0;
      sh <= '{default: '0};
      x_pos_of_ball <= BALL_X_RST;
      y_pos_of_ball <= BALL_Y_RST;
      points_player_1 <= '0;
      points_player_2 <= '0;
      who_won <= '0;
      frame_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        HUNT: if (byte_valid && !stop_err && data == SYNC_BYTE) begin
          state <= COLLECT;
          idx <= 3'd1;
          xr <= SYNC_BYTE;
          ferr <= 1'b0;
          tcnt <= '0;
        end
        COLLECT: if (byte_valid) begin
          sh[idx] <= data;
          tcnt <= '0;
          idx <= idx + 1'b1;
          if (idx != 3'(FRAME_LEN - 1)) xr <= xr ^ data;
          if (stop_err) ferr <= 1'b1;
          if (idx == 3'(FRAME_LEN - 1) || stop_err) state <= CHECK;
        end else if (tcnt == TW'(TO - 1)) begin
          frame_err <= 1'b1;
          state <= HUNT;
        end else tcnt <= tcnt + 1'b1;
        CHECK: begin
          state <= HUNT;
          if (good) begin
            x_pos_of_ball <= {sh[1][2:0], sh[2]};
            y_pos_of_ball <= {sh[3][2:0], sh[4]};
            points_player_1 <= sh[5][7:4];
            points_player_2 <= sh[5][3:0];
            who_won <= sh[6][1:0];
            frame_valid <= 1'b1;
          end else frame_err <= 1'b1;
        end
        default: state <= HUNT;
      endcase
    end
endmodule

// File: tb/tb_game_state_rx.sv
// tb_game_state_rx: directed plus randomized frame checks against a field-level model
module tb_game_state_rx;
  import game_link_pkg::*;
  localparam int CPB = 16;
  typedef logic [7:0] frame_t [8];
  logic clk65MHz = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic [10:0] x_pos_of_ball, y_pos_of_ball;
  logic [3:0] points_player_1, points_player_2;
  logic [1:0] who_won;
  logic frame_valid, frame_err;
  int checks = 0, errors = 0;
  int nv = 0, ne = 0, both = 0;
  logic [31:0] snap = '0, exp_st;
  localparam logic [31:0] RST_ST = {BALL_X_RST, BALL_Y_RST, 4'd0, 4'd0, 2'd0};

  game_state_rx #(.CLK_FREQ(1_600_000), .BAUD(100_000), .BYTE_TIMEOUT_BITS(20)) dut (
    .clk65MHz(clk65MHz), .rst_n(rst_n), .rx(rx),
    .x_pos_of_ball(x_pos_of_ball), .y_pos_of_ball(y_pos_of_ball),
    .points_player_1(points_player_1), .points_player_2(points_player_2),
    .who_won(who_won), .frame_valid(frame_valid), .frame_err(frame_err)
  );

  always #5 clk65MHz = ~clk65MHz;

  function automatic logic [31:0] obs();
    return {x_pos_of_ball, y_pos_of_ball, points_player_1, points_player_2, who_won};
  endfunction

  always @(negedge clk65MHz) begin
    if (frame_valid) begin
      nv++;
      snap = obs();
    end
    if (frame_err) ne++;
    if (frame_valid && frame_err) both++;
  end

  function automatic frame_t fix_xor(input frame_t f);
    f[7] = f[0] ^ f[1] ^ f[2] ^ f[3] ^ f[4] ^ f[5] ^ f[6];
    return f;
  endfunction

  function automatic frame_t mk(input int x, input int y, input int p1, input int p2, input int w);
    frame_t f;
    f[0] = 8'hA5;
    f[1] = 8'(x / 256);
    f[2] = 8'(x % 256);
    f[3] = 8'(y / 256);
    f[4] = 8'(y % 256);
    f[5] = 8'(p1 * 16 + p2);
    f[6] = 8'(w);
    return fix_xor(f);
  endfunction

  function automatic bit ok(input frame_t f);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 7; i++) s ^= f[i];
    return f[0] == 8'hA5 && s == f[7] && f[1] < 8 && f[3] < 8 && f[6] < 3;
  endfunction

  function automatic logic [31:0] dec(input frame_t f);
    int x, y;
    x = f[1] * 256 + f[2];
    y = f[3] * 256 + f[4];
    return {11'(x), 11'(y), f[5][7:4], f[5][3:0], f[6][1:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk65MHz);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk65MHz);
    end
    rx = stop;
    repeat (CPB) @(negedge clk65MHz);
    rx = 1'b1;
  endtask

  task automatic run_frame(input string tag, input frame_t f);
    int v0, e0;
    bit g;
    v0 = nv;
    e0 = ne;
    for (int i = 0; i < 8; i++) send_byte(f[i], 1'b1);
    repeat (4) @(negedge clk65MHz);
    g = ok(f);
    if (g) exp_st = dec(f);
    chk({tag, "_valid"}, 32'(nv - v0), g ? 32'd1 : 32'd0);
    chk({tag, "_err"}, 32'(ne - e0), g ? 32'd0 : 32'd1);
    chk({tag, "_state"}, obs(), exp_st);
    if (g) chk({tag, "_snap"}, snap, exp_st);
  endtask

  initial begin
    frame_t f, f3;
    int v0, e0, mode, bi;
    exp_st = RST_ST;
    repeat (3) @(negedge clk65MHz);
    chk("reset_state", obs(), RST_ST);
    chk("reset_pulses", {30'd0, frame_valid, frame_err}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk65MHz);

    f = mk(923, 51, 3, 7, 0);
    chk("frame1_bytes", {f[1], f[2], f[3], f[4]}, 32'h039B0033);
    f[7] ^= 8'h01;
    run_frame("bad_xor", f);
    run_frame("good1", mk(923, 51, 3, 7, 0));
    run_frame("a5_data", mk(11'h1A5, 200, 10, 5, 1));

    v0 = nv;
    e0 = ne;
    f = mk(100, 200, 1, 2, 0);
    for (int i = 0; i < 4; i++) send_byte(f[i], 1'b1);
    repeat (25 * CPB) @(negedge clk65MHz);
    chk("timeout_err", 32'(ne - e0), 32'd1);
    chk("timeout_valid", 32'(nv - v0), 32'd0);
    chk("timeout_state", obs(), exp_st);
    run_frame("after_timeout", mk(1500, 1000, 9, 9, 2));

    v0 = nv;
    e0 = ne;
    f = mk(7, 8, 2, 3, 1);
    for (int i = 0; i < 4; i++) send_byte(f[i], i != 3);
    repeat (2 * CPB) @(negedge clk65MHz);
    chk("stoperr_err", 32'(ne - e0), 32'd1);
    chk("stoperr_valid", 32'(nv - v0), 32'd0);
    chk("stoperr_state", obs(), exp_st);
    run_frame("after_stoperr", mk(2047, 2047, 15, 15, 0));

    f = mk(300, 301, 4, 4, 1);
    for (int i = 0; i < 5; i++) send_byte(f[i], 1'b1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk65MHz);
    exp_st = RST_ST;
    chk("midreset_state", obs(), RST_ST);
    chk("midreset_pulses", {30'd0, frame_valid, frame_err}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk65MHz);
    v0 = nv;
    e0 = ne;
    for (int k = 0; k < 3; k++) begin
      f = mk(10 + 100 * k, 20 + 50 * k, k, 15 - k, 2);
      for (int i = 0; i < 8; i++) send_byte(f[i], 1'b1);
      f3 = f;
    end
    repeat (4) @(negedge clk65MHz);
    exp_st = dec(f3);
    chk("b2b_valid", 32'(nv - v0), 32'd3);
    chk("b2b_err", 32'(ne - e0), 32'd0);
    chk("b2b_state", obs(), exp_st);

    for (int n = 0; n < 8; n++) begin
      f = mk(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
      mode = int'($urandom_range(0, 3));
      if (mode == 1) begin
        bi = int'($urandom_range(1, 7));
        f[bi] ^= 8'(1 << $urandom_range(0, 7));
      end else if (mode == 2) begin
        f[6] = 8'd3;
        f = fix_xor(f);
      end else if (mode == 3) begin
        f[1] |= 8'h80;
        f = fix_xor(f);
      end
      run_frame($sformatf("rand%0d_m%0d", n, mode), f);
    end

    chk("exclusive_pulses", 32'(both), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
